audio_route_sequencer: RTL and testbench
========================================

# audio_route_sequencer

Click-free audio routing controller for the codec datapath. Sits between the switch synchroniser and the headphone registers. It debounces the requested routing mode and ramps the headphone gain down to silence. It then switches the source mux between line-in and the moving-sum filter outputs and ramps the gain back up. All audio updates occur only on `new_sample` strobes from the codec interface.

## Interface
- `WIDTH`, 16, sample width (signed two's complement)
- `RAMP_SHIFT`, 5, ramp length is 2^RAMP_SHIFT samples; gain is unsigned, RAMP_SHIFT+1 bits
- `STABLE_SAMPLES`, 480, consecutive strobes a new mode must hold before switching (10 ms at 48 kHz)

Ports:
- `clk`  in  1  codec-domain clock (48 MHz)
- `rst_n`  in  1  asynchronous, active-low reset
- `new_sample`  in  1  one-cycle strobe, one per audio frame
- `mode_in`  in  2  requested route, already synchronised to `clk`
- `line_l`, `line_r`  in  WIDTH  raw line-in samples
- `filt1_l`, `filt1_r`  in  WIDTH  8-tap filter output, already scaled to WIDTH
- `filt2_l`, `filt2_r`  in  WIDTH  16-tap filter output, already scaled to WIDTH
- `hp_l`, `hp_r`  out  WIDTH  registered headphone samples
- `active_mode`  out  2  route currently applied
- `busy`  out  1  high while a gain ramp is in progress

## Operation
- Route table for `active_mode`:
  - 0: L=line_l, R=line_r
  - 1: L=line_l, R=filt1_r
  - 2: L=filt1_l, R=line_r
  - 3: L=filt2_l, R=filt2_r
- Output on a strobe: hp = (src * gain) >>> RAMP_SHIFT.
  - Signed product is WIDTH+RAMP_SHIFT+1 bits; gain is zero-extended.
  - Arithmetic shift truncates toward −inf.
  - gain = 2^RAMP_SHIFT reproduces src exactly; no saturation is needed.
- FSM states IDLE, DEBOUNCE, RAMP_DOWN, RAMP_UP. State changes only on `new_sample`.
  - IDLE: if mode_in ≠ active_mode, latch `target`=mode_in, set count=1, go to DEBOUNCE. If STABLE_SAMPLES=1, go straight to RAMP_DOWN.
  - DEBOUNCE:
    - mode_in == active_mode → IDLE.
    - mode_in ≠ target (and ≠ active_mode) → target=mode_in, count=1.
    - mode_in == target → count+1. When count reaches STABLE_SAMPLES → RAMP_DOWN.
  - RAMP_DOWN: gain−1 per strobe. On the strobe where gain==0, active_mode<=target and go to RAMP_UP; gain stays 0 on that strobe.
  - RAMP_UP: gain+1 per strobe. On the strobe where gain becomes 2^RAMP_SHIFT, go to IDLE.
- `mode_in` is ignored during both ramps. A pending difference is picked up in IDLE on the next strobe and is debounced again from count=1.
- `busy` = state ∈ {RAMP_DOWN, RAMP_UP}. Registered, so it changes on the same edge as the state.

## Timing
- Reset (async, immediate) values:
  - hp_l=hp_r=0, active_mode=0, gain=0
  - state=RAMP_UP, busy=1, target=0, count=0
- A power-up fade-in runs automatically after reset.
- On a `new_sample` edge:
  - hp_* is computed from the pre-edge gain, active_mode and inputs.
  - gain, state and active_mode update on the same edge.
  - A gain change therefore appears on the following strobe.
- Output latency is one clock after the strobe edge. hp_* holds between strobes.
- Switch duration after debounce: 2^RAMP_SHIFT+1 strobes to reach the zero-output sample, then 2^RAMP_SHIFT strobes of up-ramp.
- Back-to-back strobes (every cycle) must work.
- Deasserting `rst_n` mid-ramp or mid-debounce restarts from the reset values with no partial state kept.

## Test plan
- Reset fade-in: hold line_l=16'h4000, release rst_n, pulse 33 strobes.
  - Required: hp_l sequence 0, 16'h0200, 16'h0400, …, 16'h3E00, 16'h4000.
  - Required: busy falls at strobe 32; active_mode=0 throughout.
- Debounce reject (STABLE_SAMPLES=4), from IDLE mode 0: mode_in=3 for 3 strobes, then 0.
  - Required: busy never rises, hp unchanged, active_mode=0.
- Full switch 0→3 (STABLE_SAMPLES=4), with line_l=16'hC000 and filt2_l=16'h1000:
  - Required: after 4 strobes, RAMP_DOWN begins; hp_l goes 16'hC000, 16'hC200, …, 16'hFE00, 0.
  - Required: active_mode=3 at the zero sample, then hp_l ramps 0, 16'h0080, … up to 16'h1000, and busy falls.
- Change during ramp: at ramp-down sample 5, set mode_in=1 (target 3).
  - Required: the ramp completes to mode 3; the next IDLE strobe enters DEBOUNCE with target 1, and a second full switch follows.
- Negative truncation: src=16'hFFFF with gain=1.
  - Required: hp=16'hFFFF (floor), not 0.
- Async reset mid-ramp: assert rst_n low between strobes.
  - Required: hp=0, active_mode=0, busy=1 within the same cycle with no clock edge; on release, the fade-in repeats as in scenario 1.

Source files
------------

// File: rtl/audio_route_sequencer.sv
// Click-free headphone routing: debounces the requested route, fades the gain to
// silence, swaps the source mux, then fades back up. All audio updates happen on new_sample.
module audio_route_sequencer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned RAMP_SHIFT     = 5,
  parameter int unsigned STABLE_SAMPLES = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_sample,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] line_l,
  input  logic [WIDTH-1:0] line_r,
  input  logic [WIDTH-1:0] filt1_l,
  input  logic [WIDTH-1:0] filt1_r,
  input  logic [WIDTH-1:0] filt2_l,
  input  logic [WIDTH-1:0] filt2_r,
  output logic [WIDTH-1:0] hp_l,
  output logic [WIDTH-1:0] hp_r,
  output logic [1:0]       active_mode,
  output logic             busy
);

  localparam int unsigned GW = RAMP_SHIFT + 1;
  localparam int unsigned PW = WIDTH + RAMP_SHIFT + 1;
  localparam int unsigned CW = $clog2(STABLE_SAMPLES + 1);

  localparam logic [GW-1:0] GAIN_FULL  = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [GW-1:0] GAIN_STEP  = GW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_STABLE = CW'(STABLE_SAMPLES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, RAMP_DOWN, RAMP_UP} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   gain, gain_nx;
  logic [1:0]      target, target_nx;
  logic [1:0]      mode_nx;
  logic [CW-1:0]   count, count_nx;
  logic [WIDTH-1:0] src_l, src_r;
  logic [WIDTH-1:0] hp_l_nx, hp_r_nx;
  logic signed [PW-1:0] prod_l, prod_r;
  logic            unused_prod_bits;

  // State and datapath registers; hp uses pre-edge gain and route.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RAMP_UP;
      gain        <= '0;
      target      <= '0;
      count       <= '0;
      active_mode <= '0;
      busy        <= 1'b1;
      hp_l        <= '0;
      hp_r        <= '0;
    end else begin
      state       <= state_nx;
      gain        <= gain_nx;
      target      <= target_nx;
      count       <= count_nx;
      active_mode <= mode_nx;
      busy        <= (state_nx == RAMP_DOWN) || (state_nx == RAMP_UP);
      if (new_sample) begin
        hp_l <= hp_l_nx;
        hp_r <= hp_r_nx;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    gain_nx   = gain;
    target_nx = target;
    count_nx  = count;
    mode_nx   = active_mode;
    if (new_sample) begin
      case (state)
        IDLE: begin
          if (mode_in != active_mode) begin
            target_nx = mode_in;
            count_nx  = CNT_ONE;
            state_nx  = (STABLE_SAMPLES <= 1) ? RAMP_DOWN : DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (mode_in == active_mode) begin
            state_nx = IDLE;
          end else if (mode_in != target) begin
            target_nx = mode_in;
            count_nx  = CNT_ONE;
          end else begin
            count_nx = count + CNT_ONE;
            if (count_nx >= CNT_STABLE) state_nx = RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          // The silent sample is where the route swaps; gain holds at zero for it.
          if (gain == '0) begin
            mode_nx  = target;
            state_nx = RAMP_UP;
          end else begin
            gain_nx = gain - GAIN_STEP;
          end
        end
        RAMP_UP: begin
          gain_nx = gain + GAIN_STEP;
          if (gain_nx == GAIN_FULL) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    case (active_mode)
      2'd0:    begin src_l = line_l;  src_r = line_r;  end
      2'd1:    begin src_l = line_l;  src_r = filt1_r; end
      2'd2:    begin src_l = filt1_l; src_r = line_r;  end
      default: begin src_l = filt2_l; src_r = filt2_r; end
    endcase
    prod_l = $signed({{(RAMP_SHIFT+1){src_l[WIDTH-1]}}, src_l}) * $signed({{WIDTH{1'b0}}, gain});
    prod_r = $signed({{(RAMP_SHIFT+1){src_r[WIDTH-1]}}, src_r}) * $signed({{WIDTH{1'b0}}, gain});
    // Slicing above RAMP_SHIFT is the arithmetic shift (floor); top bit never differs from WIDTH-1.
    hp_l_nx = prod_l[WIDTH+RAMP_SHIFT-1:RAMP_SHIFT];
    hp_r_nx = prod_r[WIDTH+RAMP_SHIFT-1:RAMP_SHIFT];
    unused_prod_bits = ^{prod_l[PW-1], prod_l[RAMP_SHIFT-1:0], prod_r[PW-1], prod_r[RAMP_SHIFT-1:0]};
  end

endmodule

// File: tb/tb_audio_route_sequencer.sv
// Randomized bench for audio_route_sequencer against a schedule-queue reference model.
module tb_audio_route_sequencer;

  localparam int W    = 16;
  localparam int RS   = 5;
  localparam int SS   = 4;
  localparam int FULL = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          new_sample = 1'b0;
  logic [1:0]    mode_in = '0;
  logic [W-1:0]  line_l = '0, line_r = '0, filt1_l = '0, filt1_r = '0, filt2_l = '0, filt2_r = '0;
  logic [W-1:0]  hp_l, hp_r;
  logic [1:0]    active_mode;
  logic          busy;

  always #5 clk = ~clk;

  audio_route_sequencer #(.WIDTH(W), .RAMP_SHIFT(RS), .STABLE_SAMPLES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .new_sample(new_sample), .mode_in(mode_in),
    .line_l(line_l), .line_r(line_r), .filt1_l(filt1_l), .filt1_r(filt1_r),
    .filt2_l(filt2_l), .filt2_r(filt2_r),
    .hp_l(hp_l), .hp_r(hp_r), .active_mode(active_mode), .busy(busy)
  );

  typedef struct { int gain; int mode; } step_t;
  step_t sched[$];
  int m_mode, m_cand, m_run;
  int n_vec = 0, n_err = 0;
  bit rand_data = 1'b0;
  logic [W-1:0] last_l = '0, last_r = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // After reset the model owes a fade-in: gains 0..31 in mode 0, then idle at full gain.
  task automatic model_reset();
    step_t s;
    sched.delete();
    for (int g = 0; g < FULL; g++) begin s.gain = g; s.mode = 0; sched.push_back(s); end
    m_mode = 0; m_cand = 0; m_run = 0;
    last_l = '0; last_r = '0;
  endtask

  function automatic logic [W-1:0] pick(input int mode, input bit right);
    case (mode)
      0:       return right ? line_r  : line_l;
      1:       return right ? filt1_r : line_l;
      2:       return right ? line_r  : filt1_l;
      default: return right ? filt2_r : filt2_l;
    endcase
  endfunction

  function automatic logic [W-1:0] scale(input logic [W-1:0] s, input int g);
    int sv, p, q;
    sv = int'($signed(s));
    p  = sv * g;
    q  = p / FULL;
    if ((p % FULL) != 0 && p < 0) q = q - 1;
    return q[W-1:0];
  endfunction

  task automatic do_strobe(input logic [1:0] m);
    step_t cur, s;
    bit ramping;
    logic [W-1:0] el, er;
    int emode;
    @(negedge clk);
    mode_in = m;
    if (rand_data) begin
      line_l = W'($urandom); line_r = W'($urandom);
      filt1_l = W'($urandom); filt1_r = W'($urandom);
      filt2_l = W'($urandom); filt2_r = W'($urandom);
    end
    new_sample = 1'b1;
    @(posedge clk);
    #1;
    new_sample = 1'b0;
    ramping = sched.size() > 0;
    if (ramping) cur = sched.pop_front();
    else begin cur.gain = FULL; cur.mode = m_mode; end
    el = scale(pick(cur.mode, 1'b0), cur.gain);
    er = scale(pick(cur.mode, 1'b1), cur.gain);
    if (!ramping) begin
      if (int'(m) == m_mode) m_run = 0;
      else if (m_run > 0 && int'(m) == m_cand) m_run++;
      else begin m_cand = int'(m); m_run = 1; end
      if (m_run == SS) begin
        for (int g = FULL; g >= 0; g--) begin s.gain = g; s.mode = m_mode; sched.push_back(s); end
        for (int g = 0; g < FULL; g++) begin s.gain = g; s.mode = m_cand; sched.push_back(s); end
        m_mode = m_cand;
        m_run  = 0;
      end
    end
    emode = (sched.size() > 0) ? sched[0].mode : m_mode;
    check_eq("hp_l", hp_l, el);
    check_eq("hp_r", hp_r, er);
    check_eq("busy", busy, sched.size() > 0);
    check_eq("active_mode", active_mode, emode[1:0]);
    last_l = el; last_r = er;
  endtask

  task automatic gap_cycle();
    @(negedge clk);
    new_sample = 1'b0;
    line_l = W'($urandom); filt2_r = W'($urandom);
    @(posedge clk);
    #1;
    check_eq("hold_l", hp_l, last_l);
    check_eq("hold_r", hp_r, last_r);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_hp_l", hp_l, 16'h0000);
    check_eq("rst_hp_r", hp_r, 16'h0000);
    check_eq("rst_mode", active_mode, 2'd0);
    check_eq("rst_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic fade_in_4000();
    rand_data = 1'b0;
    line_l = 16'h4000; line_r = 16'h0000;
    for (int i = 0; i < 33; i++) do_strobe(2'd0);
    check_eq("fade_end_hp_l", hp_l, 16'h4000);
    check_eq("fade_end_busy", busy, 1'b0);
  endtask

  logic [1:0] rmode;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check_eq("por_hp_l", hp_l, 16'h0000);
    check_eq("por_busy", busy, 1'b1);
    check_eq("por_mode", active_mode, 2'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Negative floor: gain 1 on 0xFFFF must give 0xFFFF.
    rand_data = 1'b0;
    line_l = 16'hFFFF; line_r = 16'h0001;
    do_strobe(2'd0);
    do_strobe(2'd0);
    check_eq("neg_trunc", hp_l, 16'hFFFF);
    check_eq("pos_trunc", hp_r, 16'h0000);

    apply_reset();
    fade_in_4000();

    // Debounce reject: three strobes of a new mode then back.
    for (int i = 0; i < 3; i++) do_strobe(2'd3);
    do_strobe(2'd0);
    check_eq("reject_busy", busy, 1'b0);
    check_eq("reject_mode", active_mode, 2'd0);

    // Full switch 0->3.
    line_l = 16'hC000; filt2_l = 16'h1000;
    for (int i = 0; i < 4 + 65 + 1; i++) do_strobe(2'd3);
    check_eq("switch_hp_l", hp_l, 16'h1000);
    check_eq("switch_mode", active_mode, 2'd3);

    // Request mode 0, then change to 1 at ramp-down sample 5.
    for (int i = 0; i < 4 + 5; i++) do_strobe(2'd0);
    for (int i = 0; i < 150; i++) do_strobe(2'd1);
    check_eq("chg_mode", active_mode, 2'd1);
    check_eq("chg_busy", busy, 1'b0);

    // Async reset in the middle of a ramp, then fade-in repeats.
    for (int i = 0; i < 4 + 10; i++) do_strobe(2'd2);
    apply_reset();
    fade_in_4000();

    // Randomized traffic with glitchy mode requests and strobe gaps.
    rand_data = 1'b1;
    rmode = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) rmode = 2'($urandom_range(3));
      do_strobe(rmode);
      if ($urandom_range(3) == 0) gap_cycle();
      if (i == 1700) apply_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
